// File: rtl/basic_computer_pkg.sv
// Shared definitions for the basic computer: instruction field positions,
// the register/IO opcode and the fetch unit state encoding.
package basic_computer_pkg;

  localparam int ADDR_W = 12;
  localparam int WORD_W = 16;

  localparam logic [2:0] OPC_REGIO = 3'b111;

  localparam int I_BIT   = 15;
  localparam int OPC_HI  = 14;
  localparam int OPC_LO  = 12;
  localparam int ADDR_HI = 11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    F_RD  = 3'd1,
    F_CAP = 3'd2,
    I_RD  = 3'd3,
    I_CAP = 3'd4,
    D_WR  = 3'd5,
    D_RD  = 3'd6,
    D_CAP = 3'd7
  } ifu_state_t;

  // Register/IO instructions reuse the I bit as an opcode bit, so they never
  // take the second (indirect) read.
  function automatic logic is_indirect(input logic [WORD_W-1:0] word);
    return word[I_BIT] && (word[OPC_HI:OPC_LO] != OPC_REGIO);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Main-memory bus between the fetch unit (master) and the 4096x16
// synchronous-read memory (slave).
interface instr_fetch_unit_if #(
  parameter int ADDR_BITS = 12,
  parameter int WORD_BITS = 16
);

  logic [ADDR_BITS-1:0] mem_adress;
  logic                 mem_write;
  logic [WORD_BITS-1:0] mem_indata;
  logic [WORD_BITS-1:0] mem_outdata;

  modport master (
    output mem_adress,
    output mem_write,
    output mem_indata,
    input  mem_outdata
  );

  modport slave (
    input  mem_adress,
    input  mem_write,
    input  mem_indata,
    output mem_outdata
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer with indirect-address resolution and a
// single-word data port, driving a synchronous-read main memory.
module instr_fetch_unit
  import basic_computer_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int WORD_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  pc,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_BITS-1:0]  ir,
  output logic [ADDR_BITS-1:0]  ea,
  output logic [ADDR_BITS-1:0]  pc_next,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_BITS-1:0]  cpu_addr,
  input  logic [WORD_BITS-1:0]  cpu_wdata,
  output logic [WORD_BITS-1:0]  cpu_rdata,
  output logic                  cpu_ack,

  instr_fetch_unit_if.master    mem
);

  localparam logic [ADDR_BITS-1:0] PC_STEP = ADDR_BITS'(1);

  ifu_state_t state_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      ir             <= '0;
      ea             <= '0;
      pc_next        <= '0;
      cpu_rdata      <= '0;
      cpu_ack        <= 1'b0;
      mem.mem_adress <= '0;
      mem.mem_write  <= 1'b0;
      mem.mem_indata <= '0;
    end else begin
      done    <= 1'b0;
      cpu_ack <= 1'b0;

      unique case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg      <= F_RD;
            mem.mem_adress <= pc;
            pc_next        <= pc + PC_STEP;
            busy           <= 1'b1;
          // The request is still high during its own ack cycle; only a
          // request seen after that cycle is a new access.
          end else if (cpu_req && !cpu_ack) begin
            mem.mem_adress <= cpu_addr;
            if (cpu_we) begin
              state_reg      <= D_WR;
              mem.mem_indata <= cpu_wdata;
              mem.mem_write  <= 1'b1;
            end else begin
              state_reg <= D_RD;
            end
          end
        end

        F_RD: state_reg <= F_CAP;

        F_CAP: begin
          ir <= mem.mem_outdata;
          if (is_indirect(mem.mem_outdata)) begin
            mem.mem_adress <= mem.mem_outdata[ADDR_BITS-1:0];
            state_reg      <= I_RD;
          end else begin
            ea        <= mem.mem_outdata[ADDR_BITS-1:0];
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end

        I_RD: state_reg <= I_CAP;

        I_CAP: begin
          ea        <= mem.mem_outdata[ADDR_BITS-1:0];
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        // The memory commits the write on the edge that leaves this state.
        D_WR: begin
          mem.mem_write <= 1'b0;
          cpu_ack       <= 1'b1;
          state_reg     <= IDLE;
        end

        D_RD: state_reg <= D_CAP;

        D_CAP: begin
          cpu_rdata <= mem.mem_outdata;
          cpu_ack   <= 1'b1;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a behavioural 4096x16 memory on the
// bus and a word-level reference model predicting every fetch and data access.
module tb_instr_fetch_unit;

  localparam int CYCLE_LIMIT = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] pc;
  logic        busy;
  logic        done;
  logic [15:0] ir;
  logic [11:0] ea;
  logic [11:0] pc_next;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;

  int checks = 0;
  int errors = 0;

  int done_cnt  = 0;
  int ack_cnt   = 0;
  int write_cnt = 0;

  logic [15:0] mem_array [4096];
  logic [15:0] ref_mem   [4096];

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_BITS(12), .WORD_BITS(16)) mem_bus ();

  instr_fetch_unit #(.ADDR_BITS(12), .WORD_BITS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .ir        (ir),
    .ea        (ea),
    .pc_next   (pc_next),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .mem       (mem_bus.master)
  );

  function automatic logic [15:0] init_word(input int i);
    logic [31:0] x;
    x = i * 32'h9E3779B1;
    return x[31:16] ^ x[15:0];
  endfunction

  // Synchronous-read memory: a write cycle leaves outdata untouched.
  initial begin
    for (int i = 0; i < 4096; i++) mem_array[i] = init_word(i);
    mem_bus.mem_outdata <= '0;
    forever begin
      @(posedge clk);
      if (mem_bus.mem_write)
        mem_array[mem_bus.mem_adress] = mem_bus.mem_indata;
      else
        mem_bus.mem_outdata <= mem_array[mem_bus.mem_adress];
    end
  end

  // Per-cycle event counters, sampled before the edge updates the DUT.
  always @(posedge clk) begin
    if (done)              done_cnt++;
    if (cpu_ack)           ack_cnt++;
    if (mem_bus.mem_write) write_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fetch at p; optionally pulse a second start while busy, which must be dropped.
  task automatic do_fetch(input logic [11:0] p, input bit extra_start);
    logic [15:0] w;
    logic [15:0] exp_ir;
    logic [11:0] exp_ea;
    logic [11:0] exp_pcn;
    logic [15:0] target;
    bit          ind;
    int          exp_lat;
    int          n;
    bit          got;
    int          d0, a0, w0;

    w      = ref_mem[p];
    ind    = w[15] && (w[14:12] != 3'b111);
    exp_ir = w;
    target = ref_mem[w[11:0]];
    exp_ea = ind ? target[11:0] : w[11:0];
    exp_lat = ind ? 5 : 3;
    exp_pcn = 12'((int'(p) + 1) % 4096);

    d0 = done_cnt; a0 = ack_cnt; w0 = write_cnt;
    start = 1'b1;
    pc    = p;
    n = 0; got = 1'b0;
    while (!got && n < CYCLE_LIMIT) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("fetch_busy", 32'(busy), 32'd1);
        start = extra_start;
        pc    = ~p;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;

    check("fetch_latency", got ? n : 0, exp_lat);
    check("fetch_ir", 32'(ir), 32'(exp_ir));
    check("fetch_ea", 32'(ea), 32'(exp_ea));
    check("fetch_pc_next", 32'(pc_next), 32'(exp_pcn));
    check("fetch_busy_clr", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    check("fetch_done_once", done_cnt - d0, 1);
    check("fetch_no_write", write_cnt - w0, 0);
    check("fetch_no_ack", ack_cnt - a0, 0);
    $display("fetch pc=%03h ir=%04h ea=%03h pc_next=%03h lat=%0d ind=%0d extra=%0d",
             p, ir, ea, pc_next, n, ind, extra_start);
  endtask

  task automatic do_data(input bit we, input logic [11:0] a, input logic [15:0] wd);
    logic [15:0] exp_rd;
    int          n;
    bit          got;
    int          a0, w0;

    exp_rd = ref_mem[a];
    a0 = ack_cnt; w0 = write_cnt;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    n = 0; got = 1'b0;
    while (!got && n < CYCLE_LIMIT) begin
      @(negedge clk);
      n++;
      if (cpu_ack) got = 1'b1;
    end
    cpu_req = 1'b0;

    if (we) begin
      check("wr_ack_latency", got ? n - 1 : 99, 1);
      ref_mem[a] = wd;
    end else begin
      check("rd_ack_latency", got ? n - 1 : 99, 2);
      check("rd_data", 32'(cpu_rdata), 32'(exp_rd));
    end
    repeat (2) @(negedge clk);
    check("data_ack_once", ack_cnt - a0, 1);
    check("data_write_cycles", write_cnt - w0, we ? 1 : 0);
    $display("data %s addr=%03h wdata=%04h rdata=%04h lat=%0d",
             we ? "wr" : "rd", a, wd, cpu_rdata, n - 1);
  endtask

  initial begin
    int n, done_n, ack_n, d0;

    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);

    reset = 1'b1; start = 1'b0; pc = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_ea", 32'(ea), 32'd0);
    check("rst_pc_next", 32'(pc_next), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_mem_write", 32'(mem_bus.mem_write), 32'd0);
    check("rst_mem_adress", 32'(mem_bus.mem_adress), 32'd0);
    check("rst_mem_indata", 32'(mem_bus.mem_indata), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed program image, loaded through the data port.
    do_data(1'b1, 12'h010, 16'h2345);
    do_data(1'b1, 12'h020, 16'h9100);
    do_data(1'b1, 12'h100, 16'h0ABC);
    do_data(1'b1, 12'h030, 16'hF800);

    do_fetch(12'h010, 1'b0);
    do_fetch(12'h020, 1'b0);
    do_fetch(12'h030, 1'b0);
    do_fetch(12'hFFF, 1'b0);
    do_fetch(12'h020, 1'b1);

    do_data(1'b1, 12'h200, 16'hBEEF);
    do_data(1'b0, 12'h200, 16'h0000);

    // Arbitration: fetch wins, the held read is served after done.
    start = 1'b1; pc = 12'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    n = 0; done_n = 0; ack_n = 0;
    while (ack_n == 0 && n < CYCLE_LIMIT) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done && done_n == 0) done_n = n;
      if (cpu_ack) ack_n = n;
    end
    cpu_req = 1'b0;
    check("arb_done_cycle", done_n, 3);
    check("arb_ack_cycle", ack_n, 6);
    check("arb_ir", 32'(ir), 32'h2345);
    check("arb_rdata", 32'(cpu_rdata), 32'hBEEF);
    $display("arb fetch_done=%0d read_ack=%0d rdata=%04h", done_n, ack_n, cpu_rdata);
    repeat (2) @(negedge clk);

    // Reset while waiting on the indirect read.
    d0 = done_cnt;
    start = 1'b1; pc = 12'h020;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst_in_ind_read", 32'(mem_bus.mem_adress), 32'h100);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ea", 32'(ea), 32'd0);
    check("midrst_ir", 32'(ir), 32'd0);
    check("midrst_mem_adress", 32'(mem_bus.mem_adress), 32'd0);
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    $display("midrst busy=%0d ea=%03h", busy, ea);
    do_fetch(12'h020, 1'b0);

    // Random mix of fetches and data accesses.
    for (int it = 0; it < 120; it++) begin
      int op;
      op = int'($urandom_range(0, 3));
      case (op)
        0, 1:    do_fetch(12'($urandom), 1'($urandom));
        2:       do_data(1'b1, 12'($urandom), 16'($urandom));
        default: do_data(1'b0, 12'($urandom), 16'h0000);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
